// File: rtl/fifo_ptr_pkg.sv
// rtl/fifo_ptr_pkg.sv - shared pointer sizing helpers and types for the async FIFO controllers
package fifo_ptr_pkg;

   localparam int DEF_ADDR_W = 4;

   function automatic int ptr_w(input int addr_w);
      return addr_w + 1;
   endfunction

   function automatic int depth(input int addr_w);
      return 1 << addr_w;
   endfunction

   typedef logic [ptr_w(DEF_ADDR_W)-1:0] ptr_t;

endpackage

// File: rtl/binary_to_gray.sv
// rtl/binary_to_gray.sv - combinational binary to reflected Gray code converter
module binary_to_gray #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);

   assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_to_binary.sv
// rtl/gray_to_binary.sv - combinational Gray to binary converter (prefix XOR from the MSB)
module gray_to_binary #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign bin[i] = ^(gray >> i);
   end

endmodule

// File: rtl/fifo_wptr_ctrl.sv
// rtl/fifo_wptr_ctrl.sv - async FIFO write-side pointer, Gray export, full/almost-full/level
module fifo_wptr_ctrl
   import fifo_ptr_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int AF_THRESH  = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_req,
   input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
   output logic                  wen,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [ADDR_WIDTH:0]   wptr_gray,
   output logic                  full,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   level
);

   localparam int PW = ptr_w(ADDR_WIDTH);
   localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);

   logic [PW-1:0] wbin;
   logic [PW-1:0] wbin_next;
   logic [PW-1:0] gray_next;
   logic [PW-1:0] rbin;
   logic [PW-1:0] level_next;
   logic          full_next;

   assign wen       = wr_req & ~full & rst_n;
   assign waddr     = wbin[ADDR_WIDTH-1:0];
   assign wbin_next = wbin + PW'(wen);

   binary_to_gray #(.WIDTH(PW)) u_b2g (
      .bin  (wbin_next),
      .gray (gray_next)
   );

   gray_to_binary #(.WIDTH(PW)) u_g2b (
      .gray (rptr_gray_sync),
      .bin  (rbin)
   );

   assign level_next = wbin_next - rbin;
   // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted, rest equal.
   assign full_next  = (gray_next == {~rptr_gray_sync[PW-1:PW-2], rptr_gray_sync[PW-3:0]});

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wbin        <= '0;
         wptr_gray   <= '0;
         level       <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
      end else begin
         wbin        <= wbin_next;
         wptr_gray   <= gray_next;
         level       <= level_next;
         full        <= full_next;
         almost_full <= (level_next >= AF_LVL);
      end
   end

endmodule
